deser_2ph_fifo: RTL and testbench
=================================

Name: deser_2ph_fifo

Overview:
Parametrised successor to the fixed 32-bit serial-in word deserializer. It qualifies serial bits with a valid strobe and re-aligns on a start-of-frame marker. Completed words are buffered in a small FIFO and handed downstream over a two-phase (toggle) req/ack handshake. It sits between the serial link receiver and the scrambler/consumer stage, all on one clock.

Parameters:
- DATA_W, 32, word width in bits (>=2).
- FIFO_DEPTH, 4, buffered words; power of two, >=2.
- LSB_FIRST, 1, 1 = first received bit is bit 0; 0 = first received bit is bit DATA_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  1  serial data bit.
- din_vld  input  1  din sampled only when high.
- sof  input  1  start of frame; qualified by din_vld.
- dout  output  DATA_W  word presented to consumer.
- req  output  1  two-phase request; toggles once per new dout.
- ack  input  1  two-phase acknowledge; consumer sets ack=req when dout consumed.
- ovf  output  1  sticky overflow flag.
- ovf_clr  input  1  clears ovf.
- level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset is asynchronous. All of the following clear immediately on rst without a clock edge: bit counter=0, shift register=0, FIFO empty, level=0, dout=0, req=0, ovf=0, FSM=IDLE.
- Reset mid-frame discards the partial word and all queued words. The consumer must also return ack to 0.
- Shift register:
  - Updates only when din_vld=1.
  - LSB_FIRST=1: sh <= {din, sh[DATA_W-1:1]}.
  - LSB_FIRST=0: sh <= {sh[DATA_W-2:0], din}.
- Bit counter:
  - Range 0..DATA_W-1; increments on each din_vld.
  - When it is at DATA_W-1 with din_vld, the word is complete: the post-shift value is pushed to the FIFO at that edge and the counter wraps to 0.
- sof with din_vld:
  - The bit on that cycle is taken as bit position 0 of a new word, and the counter becomes 1.
  - Any partial word is discarded without flagging.
  - If DATA_W=... is irrelevant here: sof is never itself a word completion.
  - sof without din_vld is ignored.
- FIFO:
  - Push when full (pre-edge count==FIFO_DEPTH) and no pop on the same edge: the word is dropped and ovf is set.
  - Push and pop on the same edge when full: the push is accepted and level is unchanged.
  - Order is strictly preserved.
- ovf:
  - Sticky; cleared by ovf_clr.
  - If a set and ovf_clr coincide, set wins.
- Output FSM, two states:
  - IDLE: if FIFO not empty, at the next edge load dout from the FIFO head, pop, toggle req, and go to WAIT_ACK.
  - WAIT_ACK: dout and req are held stable. On an edge where ack==req, go to IDLE.
  - The earliest next req toggle is the following edge.
- Latency: the last bit of a word is sampled at edge k. It is pushed at edge k. With the FSM in IDLE and the FIFO previously empty, dout and the req toggle are visible after edge k+1.
- An ack change while in IDLE (ack!=req) is a protocol error and is ignored. No state change results.
- level reflects registered FIFO occupancy. It excludes the word held in dout.

Decomposition:
- Shared definitions package: the FSM state enum (IDLE, WAIT_ACK) as a typedef, shared by this block and future 2-phase senders.
- Word type stays local because it depends on DATA_W.
- One sub-module: sync_fifo, parametrised by width/depth, with push, pop, full, empty and count. Serial shift logic and the 2-phase FSM stay in deser_2ph_fifo.

Test Plan:
- Basic word: DATA_W=32, LSB_FIRST=1, din_vld constant 1, send 0xA5C30F81; consumer echoes req after 3 cycles -> req 0->1 one edge after the 32nd-bit edge, dout=0xA5C30F81, level returns to 0, ovf=0.
- Re-alignment: 10 random bits, then sof with the first bit of 0x12345678, then its remaining 31 bits -> exactly one req toggle, dout=0x12345678.
- Gapped valid: send 0xDEADBEEF with din_vld low every other cycle, din random while low -> dout=0xDEADBEEF, one req toggle, no extra pushes.
- Overflow: FIFO_DEPTH=4, ack held, send words 1..6 -> dout=1, level=4, word 6 dropped, ovf=1. Then toggle ack four times -> dout 2,3,4,5 in order. ovf_clr -> ovf=0.
- Bit order: LSB_FIRST=0, send 0x80000001 MSB first -> dout=0x80000001. Send 0x00000002 -> dout=0x00000002.
- Async reset: assert rst between clock edges after 17 bits with 2 words queued -> dout=0, req=0, level=0, ovf=0 immediately. After release, send 0x0000FFFF -> req 0->1, dout=0x0000FFFF.

Source files
------------

// File: rtl/deser_2ph_fifo_pkg.sv
// Shared definitions for two-phase (toggle) req/ack senders.
package deser_2ph_fifo_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_t;

    // A transfer is outstanding while the consumer has not echoed req on ack.
    function automatic logic hs_pending(input logic req, input logic ack);
        return req != ack;
    endfunction

endpackage

// File: rtl/deser_2ph_fifo_if.sv
// Serial input, word output and status bundle of the deserializer.
interface deser_2ph_fifo_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              din;
    logic              din_vld;
    logic              sof;
    logic [DATA_W-1:0] dout;
    logic              req;
    logic              ack;
    logic              ovf;
    logic              ovf_clr;
    logic [LVL_W-1:0]  level;

    modport master (
        input  din, din_vld, sof, ack, ovf_clr,
        output dout, req, ovf, level
    );

    modport slave (
        output din, din_vld, sof, ack, ovf_clr,
        input  dout, req, ovf, level
    );
endinterface

// File: rtl/deser_2ph_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head; a push when full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_pop_c  = pop && !empty_c;
    assign do_push_c = push && (!full_c || do_pop_c);
    assign head_c    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/deser_2ph_fifo.sv
// Serial-to-word deserializer with start-of-frame realignment, word FIFO and
// two-phase req/ack output handshake.
module deser_2ph_fifo
    import deser_2ph_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             rst,
    deser_2ph_fifo_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [DATA_W-1:0] word_t;

    // The bit shifted out on each update is never observed, so only DATA_W-1 bits are kept.
    logic [DATA_W-2:0] sh;
    word_t             sh_nxt_c;
    logic [CNT_W-1:0]  cnt;
    logic              push_c;
    logic              pop_c;
    logic              ovf_set_c;
    logic              ovf_q;

    word_t             head_c;
    logic              full_c;
    logic              empty_c;
    logic [LVL_W-1:0]  fifo_count;

    hs_state_t         state;
    hs_state_t         state_nxt;
    word_t             dout_q;
    word_t             dout_nxt;
    logic              req_q;
    logic              req_nxt;

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign sh_nxt_c = {bus.din, sh};
        end else begin : g_msb_first
            assign sh_nxt_c = {sh, bus.din};
        end
    endgenerate

    // sof restarts the word, so it can never complete one.
    assign push_c    = bus.din_vld && !bus.sof && (cnt == CNT_W'(DATA_W - 1));
    assign ovf_set_c = push_c && full_c && !pop_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh    <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (bus.din_vld) begin
                sh <= (LSB_FIRST != 0) ? sh_nxt_c[DATA_W-1:1] : sh_nxt_c[DATA_W-2:0];
                if (bus.sof)
                    cnt <= CNT_W'(1);
                else if (cnt == CNT_W'(DATA_W - 1))
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
            if (ovf_set_c)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (sh_nxt_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dout_q <= '0;
            req_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            dout_q <= dout_nxt;
            req_q  <= req_nxt;
        end
    end

    // Stray ack changes in IDLE are ignored; only WAIT_ACK looks at ack.
    always_comb begin
        state_nxt = state;
        dout_nxt  = dout_q;
        req_nxt   = req_q;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    dout_nxt  = head_c;
                    req_nxt   = ~req_q;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!hs_pending(req_q, bus.ack)) state_nxt = IDLE;
            end
        endcase
    end

    assign bus.dout  = dout_q;
    assign bus.req   = req_q;
    assign bus.ovf   = ovf_q;
    assign bus.level = fifo_count;

endmodule

// File: tb/tb_deser_2ph_fifo.sv
// Directed bench for deser_2ph_fifo: one LSB-first and one MSB-first instance.
module tb_deser_2ph_fifo;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic exp_req0;
    logic exp_req1;

    deser_2ph_fifo_if #(.DATA_W(32), .FIFO_DEPTH(4)) if0 ();
    deser_2ph_fifo_if #(.DATA_W(32), .FIFO_DEPTH(4)) if1 ();

    deser_2ph_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .LSB_FIRST(1)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    deser_2ph_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .LSB_FIRST(0)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic d, input logic v, input logic s);
        if (sel == 0) begin
            if0.din = d; if0.din_vld = v; if0.sof = s;
        end else begin
            if1.din = d; if1.din_vld = v; if1.sof = s;
        end
    endtask

    task automatic send_bits(input int sel, input logic [31:0] w, input int nbits,
                             input bit use_sof, input bit gapped, input bit msb_first);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, msb_first ? w[31-i] : w[i], 1'b1, use_sof && (i == 0));
            tick();
            if (gapped) begin
                drive(sel, 1'($urandom), 1'b0, 1'($urandom));
                tick();
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input bit use_sof,
                             input bit gapped, input bit msb_first);
        send_bits(sel, w, 32, use_sof, gapped, msb_first);
    endtask

    initial begin
        logic [31:0] junk;
        n_cmp = 0;
        n_err = 0;
        exp_req0 = 1'b0;
        exp_req1 = 1'b0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        if0.ack = 1'b0; if0.ovf_clr = 1'b0;
        if1.ack = 1'b0; if1.ovf_clr = 1'b0;

        #3;
        check_eq("reset_dout",  if0.dout, 32'h0);
        check_eq("reset_req",   32'(if0.req), 32'h0);
        check_eq("reset_level", 32'(if0.level), 32'h0);
        check_eq("reset_ovf",   32'(if0.ovf), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Basic word: pushed at last-bit edge, presented one edge later.
        send_word(0, 32'hA5C30F81, 1'b0, 1'b0, 1'b0);
        check_eq("basic_level_pushed", 32'(if0.level), 32'd1);
        check_eq("basic_req_not_yet",  32'(if0.req), 32'(exp_req0));
        tick();
        exp_req0 = ~exp_req0;
        check_eq("basic_req_toggle", 32'(if0.req), 32'(exp_req0));
        check_eq("basic_dout",       if0.dout, 32'hA5C30F81);
        check_eq("basic_level_zero", 32'(if0.level), 32'd0);
        tick(); tick(); tick();
        check_eq("basic_req_held",  32'(if0.req), 32'(exp_req0));
        check_eq("basic_dout_held", if0.dout, 32'hA5C30F81);
        if0.ack = exp_req0;
        tick();
        check_eq("basic_ovf", 32'(if0.ovf), 32'd0);

        // Re-alignment on sof after 10 stray bits.
        junk = $urandom;
        send_bits(0, junk, 10, 1'b0, 1'b0, 1'b0);
        send_word(0, 32'h12345678, 1'b1, 1'b0, 1'b0);
        check_eq("realign_level", 32'(if0.level), 32'd1);
        tick();
        exp_req0 = ~exp_req0;
        check_eq("realign_req",  32'(if0.req), 32'(exp_req0));
        check_eq("realign_dout", if0.dout, 32'h12345678);
        if0.ack = exp_req0;
        tick(); tick(); tick();
        check_eq("realign_single_req", 32'(if0.req), 32'(exp_req0));
        check_eq("realign_level_zero", 32'(if0.level), 32'd0);

        // Gapped valid with random din/sof while invalid.
        send_word(0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        tick();
        exp_req0 = ~exp_req0;
        check_eq("gapped_req",  32'(if0.req), 32'(exp_req0));
        check_eq("gapped_dout", if0.dout, 32'hDEADBEEF);
        if0.ack = exp_req0;
        tick(); tick(); tick();
        check_eq("gapped_single_req", 32'(if0.req), 32'(exp_req0));
        check_eq("gapped_level_zero", 32'(if0.level), 32'd0);

        // Overflow: ack held while six words arrive.
        for (int n = 1; n <= 6; n++) send_word(0, 32'(n), 1'b0, 1'b0, 1'b0);
        exp_req0 = ~exp_req0;
        check_eq("ovf_dout1", if0.dout, 32'd1);
        check_eq("ovf_level", 32'(if0.level), 32'd4);
        check_eq("ovf_flag",  32'(if0.ovf), 32'd1);
        check_eq("ovf_req",   32'(if0.req), 32'(exp_req0));
        for (int n = 2; n <= 5; n++) begin
            if0.ack = exp_req0;
            tick();
            tick();
            exp_req0 = ~exp_req0;
            check_eq($sformatf("ovf_dout%0d", n), if0.dout, 32'(n));
            check_eq($sformatf("ovf_level_after%0d", n), 32'(if0.level), 32'(5 - n));
            check_eq($sformatf("ovf_req%0d", n), 32'(if0.req), 32'(exp_req0));
        end
        check_eq("ovf_sticky", 32'(if0.ovf), 32'd1);
        if0.ack = exp_req0;
        if0.ovf_clr = 1'b1;
        tick();
        if0.ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(if0.ovf), 32'd0);
        tick();
        check_eq("ovf_no_word6", 32'(if0.req), 32'(exp_req0));

        // MSB-first instance.
        send_word(1, 32'h80000001, 1'b0, 1'b0, 1'b1);
        tick();
        exp_req1 = ~exp_req1;
        check_eq("msb_req1",  32'(if1.req), 32'(exp_req1));
        check_eq("msb_dout1", if1.dout, 32'h80000001);
        if1.ack = exp_req1;
        tick();
        send_word(1, 32'h00000002, 1'b0, 1'b0, 1'b1);
        tick();
        exp_req1 = ~exp_req1;
        check_eq("msb_req2",  32'(if1.req), 32'(exp_req1));
        check_eq("msb_dout2", if1.dout, 32'h00000002);
        if1.ack = exp_req1;
        tick();

        // Async reset with one word held, two queued and a partial word in flight.
        send_word(0, 32'h11111111, 1'b0, 1'b0, 1'b0);
        send_word(0, 32'h22222222, 1'b0, 1'b0, 1'b0);
        send_word(0, 32'h33333333, 1'b0, 1'b0, 1'b0);
        send_bits(0, 32'h0001FFFF, 17, 1'b0, 1'b0, 1'b0);
        exp_req0 = ~exp_req0;
        check_eq("arst_pre_level", 32'(if0.level), 32'd2);
        check_eq("arst_pre_dout",  if0.dout, 32'h11111111);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_dout",  if0.dout, 32'h0);
        check_eq("arst_req",   32'(if0.req), 32'h0);
        check_eq("arst_level", 32'(if0.level), 32'h0);
        check_eq("arst_ovf",   32'(if0.ovf), 32'h0);
        check_eq("arst_dout_msb", if1.dout, 32'h0);
        if0.ack = 1'b0;
        if1.ack = 1'b0;
        exp_req0 = 1'b0;
        exp_req1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        send_word(0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_req_before", 32'(if0.req), 32'(exp_req0));
        tick();
        exp_req0 = ~exp_req0;
        check_eq("post_rst_req",  32'(if0.req), 32'(exp_req0));
        check_eq("post_rst_dout", if0.dout, 32'h0000FFFF);
        check_eq("post_rst_level", 32'(if0.level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
